// File: rtl/exc_redirect_ctrl_pkg.sv
// cpu_exc_pkg: shared exception-controller state encoding, default vector and CP0 exc-kind codes
package cpu_exc_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_e;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_NORMAL = 2'd1;
  localparam logic [1:0] EXC_SLOT = 2'd2;
endpackage

// File: rtl/exc_redirect_ctrl_if.sv
// exc_redirect_ctrl_if: fetch redirect handshake (master drives redirect_valid/redirect_pc, slave drives redirect_ready)
interface exc_redirect_ctrl_if;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic redirect_ready;
  modport master(output redirect_valid, redirect_pc, input redirect_ready);
  modport slave(input redirect_valid, redirect_pc, output redirect_ready);
endinterface

// File: rtl/exc_redirect_ctrl_stat_counter.sv
// exc_stat_counter: CNT_W-wide wrapping event counter (clk, rst async, inc_i enable, count_o value)
module exc_stat_counter #(parameter int CNT_W = 32) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  output logic [CNT_W-1:0] count_o
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count_o <= '0;
    else if (inc_i) count_o <= count_o + 1'b1;
endmodule

// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: CP0 exception/eret to flush-then-redirect sequencer (clk, rst async; exc/eret requests in; flush, busy, last_slot, counters out; redirect handshake on rd)
module exc_redirect_ctrl import cpu_exc_pkg::*; #(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic exc_req,
  input  logic exc_slot,
  input  logic eret_req,
  input  logic [31:0] epc,
  exc_redirect_ctrl_if.master rd,
  output logic flush,
  output logic busy,
  output logic last_slot,
  output logic [CNT_W-1:0] exc_count,
  output logic [CNT_W-1:0] eret_count
);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  state_e state_q;
  logic [3:0] cnt_q;
  logic idle, exc_inc, eret_inc;
  assign idle = state_q == IDLE;
  assign exc_inc = idle && exc_req;
  assign eret_inc = idle && eret_req && !exc_req;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      flush <= 1'b0;
      busy <= 1'b0;
      last_slot <= 1'b0;
      rd.redirect_valid <= 1'b0;
      rd.redirect_pc <= '0;
    end else
      case (state_q)
        IDLE:
          if (exc_req || eret_req) begin
            state_q <= FLUSH;
            cnt_q <= FLUSH_LOAD;
            flush <= 1'b1;
            busy <= 1'b1;
            rd.redirect_pc <= exc_req ? EXC_VECTOR : epc;
            if (exc_req) last_slot <= exc_slot;
          end
        FLUSH:
          if (cnt_q == 4'd0) begin
            state_q <= REDIRECT;
            flush <= 1'b0;
            rd.redirect_valid <= 1'b1;
          end else cnt_q <= cnt_q - 4'd1;
        REDIRECT:
          if (rd.redirect_ready) begin
            state_q <= IDLE;
            rd.redirect_valid <= 1'b0;
            busy <= 1'b0;
          end
        default: state_q <= IDLE;
      endcase
  exc_stat_counter #(.CNT_W(CNT_W)) u_exc_cnt (.clk(clk), .rst(rst), .inc_i(exc_inc), .count_o(exc_count));
  exc_stat_counter #(.CNT_W(CNT_W)) u_eret_cnt (.clk(clk), .rst(rst), .inc_i(eret_inc), .count_o(eret_count));
endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// tb_exc_redirect_ctrl: directed self-checking bench for exc_redirect_ctrl
module tb_exc_redirect_ctrl;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  logic clk = 1'b0, rst = 1'b1, exc_req = 1'b0, exc_slot = 1'b0, eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic flush, busy, last_slot;
  logic [CW-1:0] exc_count, eret_count;
  int vec = 0, errs = 0;
  exc_redirect_ctrl_if rif();
  always #5 clk = ~clk;
  exc_redirect_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_slot(exc_slot), .eret_req(eret_req), .epc(epc),
    .rd(rif), .flush(flush), .busy(busy), .last_slot(last_slot), .exc_count(exc_count), .eret_count(eret_count));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic e, input logic s, input logic r, input logic [31:0] p);
    exc_req = e; exc_slot = s; eret_req = r; epc = p;
    step();
    exc_req = 1'b0; eret_req = 1'b0;
  endtask
  task automatic test_reset();
    rif.redirect_ready = 1'b0;
    step(); step();
    vec++;
    if ({flush, rif.redirect_valid, busy, last_slot, rif.redirect_pc, exc_count, eret_count} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got f=%b v=%b b=%b ls=%b pc=%h ec=%0d rc=%0d, expected all 0",
               flush, rif.redirect_valid, busy, last_slot, rif.redirect_pc, exc_count, eret_count);
    end
    rst = 1'b0;
    step();
  endtask
  task automatic test_exc(input string tag, input logic [CW-1:0] ec);
    rif.redirect_ready = 1'b1;
    req(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      vec++;
      if ({flush, rif.redirect_valid, busy} !== 3'b101) begin
        errs++; $display("FAIL %s_flush%0d fvb=%b expected 101", tag, i, {flush, rif.redirect_valid, busy});
      end
      step();
    end
    vec++;
    if ({flush, rif.redirect_valid, busy, rif.redirect_pc} !== {3'b011, VEC}) begin
      errs++; $display("FAIL %s_redirect fvb=%b pc=%h expected 011 %h", tag, {flush, rif.redirect_valid, busy}, rif.redirect_pc, VEC);
    end
    step();
    vec++;
    if ({flush, rif.redirect_valid, busy} !== 3'b000) begin
      errs++; $display("FAIL %s_idle fvb=%b expected 000", tag, {flush, rif.redirect_valid, busy});
    end
    vec++;
    if ({exc_count, last_slot} !== {ec, 1'b0}) begin
      errs++; $display("FAIL %s_stats ec=%0d ls=%b expected %0d 0", tag, exc_count, last_slot, ec);
    end
  endtask
  task automatic test_eret_backpressure();
    rif.redirect_ready = 1'b0;
    req(1'b0, 1'b0, 1'b1, 32'h8000_1234);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      vec++;
      if ({flush, rif.redirect_valid, busy, rif.redirect_pc} !== {3'b011, 32'h8000_1234}) begin
        errs++; $display("FAIL eret_hold%0d fvb=%b pc=%h expected 011 80001234", i, {flush, rif.redirect_valid, busy}, rif.redirect_pc);
      end
      if (i == 3) rif.redirect_ready = 1'b1;
      step();
    end
    vec++;
    if ({rif.redirect_valid, busy, eret_count, exc_count} !== {2'b00, 4'd1, 4'd1}) begin
      errs++; $display("FAIL eret_done v=%b b=%b rc=%0d ec=%0d expected 0 0 1 1", rif.redirect_valid, busy, eret_count, exc_count);
    end
  endtask
  task automatic test_simultaneous();
    rif.redirect_ready = 1'b1;
    req(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    step(); step();
    vec++;
    if ({rif.redirect_valid, rif.redirect_pc} !== {1'b1, VEC}) begin
      errs++; $display("FAIL simul_pc v=%b pc=%h expected 1 %h", rif.redirect_valid, rif.redirect_pc, VEC);
    end
    step();
    vec++;
    if ({exc_count, eret_count, last_slot} !== {4'd2, 4'd1, 1'b1}) begin
      errs++; $display("FAIL simul_stats ec=%0d rc=%0d ls=%b expected 2 1 1", exc_count, eret_count, last_slot);
    end
  endtask
  task automatic test_busy_drop();
    int redirects = 0;
    rif.redirect_ready = 1'b0;
    req(1'b1, 1'b0, 1'b0, 32'h0);
    req(1'b1, 1'b1, 1'b0, 32'h0);
    vec++;
    if ({flush, busy} !== 2'b11) begin
      errs++; $display("FAIL drop_flush fb=%b expected 11", {flush, busy});
    end
    step();
    req(1'b0, 1'b0, 1'b1, 32'h0000_1111);
    vec++;
    if ({rif.redirect_valid, rif.redirect_pc} !== {1'b1, VEC}) begin
      errs++; $display("FAIL drop_redirect v=%b pc=%h expected 1 %h", rif.redirect_valid, rif.redirect_pc, VEC);
    end
    rif.redirect_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rif.redirect_valid) redirects++;
      step();
    end
    vec++;
    if (redirects != 1) begin
      errs++; $display("FAIL drop_redirect_count got %0d expected 1", redirects);
    end
    vec++;
    if ({exc_count, eret_count, last_slot, busy} !== {4'd3, 4'd1, 1'b0, 1'b0}) begin
      errs++; $display("FAIL drop_stats ec=%0d rc=%0d ls=%b b=%b expected 3 1 0 0", exc_count, eret_count, last_slot, busy);
    end
  endtask
  task automatic test_reset_mid();
    rif.redirect_ready = 1'b0;
    req(1'b1, 1'b1, 1'b0, 32'h0);
    step(); step();
    vec++;
    if (rif.redirect_valid !== 1'b1) begin
      errs++; $display("FAIL rstmid_pre v=%b expected 1", rif.redirect_valid);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({flush, rif.redirect_valid, busy, last_slot, rif.redirect_pc, exc_count, eret_count} !== '0) begin
      errs++;
      $display("FAIL rstmid_async f=%b v=%b b=%b ls=%b pc=%h ec=%0d rc=%0d expected all 0",
               flush, rif.redirect_valid, busy, last_slot, rif.redirect_pc, exc_count, eret_count);
    end
    #1 rst = 1'b0;
    rif.redirect_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vec++;
      if ({rif.redirect_valid, busy} !== 2'b00) begin
        errs++; $display("FAIL rstmid_after%0d vb=%b expected 00", i, {rif.redirect_valid, busy});
      end
    end
    test_exc("rstmid_exc", 4'd1);
  endtask
  task automatic test_wrap();
    rst = 1'b1;
    #2 rst = 1'b0;
    rif.redirect_ready = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 1'b0, 1'b0, 32'h0);
      step(); step(); step();
      vec++;
      if (exc_count !== 4'(i + 1)) begin
        errs++; $display("FAIL wrap%0d ec=%0d expected %0d", i, exc_count, 4'(i + 1));
      end
    end
  endtask
  initial begin
    rif.redirect_ready = 1'b0;
    test_reset();
    test_exc("exc", 4'd1);
    test_eret_backpressure();
    test_simultaneous();
    test_busy_drop();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/exc_redirect_ctrl.md
Name: exc_redirect_ctrl

Overview:
- Pipeline-side consumer of the coprocessor-0 exception and return signalling.
- Receives the exception-taken pulse (normal or delay-slot) and the eret request.
- Sequences a multi-cycle pipeline flush.
- Then delivers a PC redirect to the fetch stage over a valid/ready handshake: the exception vector for exceptions, the EPC for eret.
- Sits between the CP0 block and IF. Also keeps taken-exception and eret statistics counters.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every exception.
- FLUSH_CYCLES, 2, cycles flush is held asserted before redirect (legal 1..15).
- CNT_W, 32, width of statistics counters.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- exc_req  input  1  exception taken this cycle (CP0 exc!=0), single-cycle pulse.
- exc_slot  input  1  qualifies exc_req: 1 = faulting instr in branch delay slot (CP0 exc==2).
- eret_req  input  1  eret committed this cycle, single-cycle pulse.
- epc  input  32  current EPC from CP0; sampled on eret_req.
- redirect_ready  input  1  fetch accepts redirect this cycle.
- flush  output  1  kill all in-flight instructions IF..MEM.
- redirect_valid  output  1  redirect_pc is valid.
- redirect_pc  output  32  new fetch address.
- busy  output  1  controller not IDLE; upstream must stall issue.
- last_slot  output  1  exc_slot captured at last accepted exception.
- exc_count  output  CNT_W  accepted exceptions, wraps.
- eret_count  output  CNT_W  accepted erets, wraps.

Behaviour:
- Reset (async): state=IDLE, flush=0, redirect_valid=0, redirect_pc=0, busy=0, last_slot=0, exc_count=0, eret_count=0, internal flush counter=0. Reset mid-operation aborts immediately; no redirect is issued.
- States: IDLE, FLUSH, REDIRECT. All outputs are registered.
- IDLE, exc_req=1 at edge N:
  - target=EXC_VECTOR; last_slot<=exc_slot; exc_count+=1; go FLUSH.
  - exc_req has priority when eret_req is also high; the eret is dropped and eret_count is unchanged.
- IDLE, eret_req=1 (exc_req=0) at edge N:
  - target=epc sampled at edge N, used unmodified including misaligned [1:0]; fetch-address errors are CP0's job.
  - eret_count+=1; go FLUSH.
- FLUSH:
  - flush=1 and busy=1 for exactly FLUSH_CYCLES cycles, i.e. cycles N+1..N+FLUSH_CYCLES.
  - Down-counter loaded with FLUSH_CYCLES-1 on entry; leave when it hits 0.
- REDIRECT:
  - flush=0, redirect_valid=1, redirect_pc=target, busy=1.
  - Held stable until the edge where redirect_ready=1; at that edge, next cycle is IDLE with redirect_valid=0.
  - redirect_ready high on the first REDIRECT cycle gives a one-cycle redirect_valid.
- exc_req/eret_req arriving in FLUSH or REDIRECT are ignored, with no counter change; CP0's EXL masks further exceptions.
- redirect_ready outside REDIRECT has no effect.
- Minimum request-to-IDLE latency: FLUSH_CYCLES+1 cycles after the request edge.
- Counters wrap from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package cpu_exc_pkg:
  - state enum {IDLE, FLUSH, REDIRECT};
  - EXC_VECTOR_DEFAULT constant;
  - exception-kind constants EXC_NONE=0, EXC_NORMAL=1, EXC_SLOT=2, matching CP0 exc encoding.
- One natural sub-module: exc_stat_counter (enable-increment wrap counter, CNT_W wide), instantiated twice for exc_count and eret_count.
- FSM and target register stay in the top.

Test Plan:
- Exception path, FLUSH_CYCLES=2, ready=1:
  - Stimulus: exc_req=1, exc_slot=0 at edge 0.
  - Response: flush=1 in cycles 1–2; redirect_valid=1, redirect_pc=BFC00380 in cycle 3; IDLE in cycle 4; exc_count=1, last_slot=0.
- Eret path with fetch backpressure:
  - Stimulus: eret_req=1 with epc=0x8000_1234; ready held 0 for 3 REDIRECT cycles, then 1.
  - Response: redirect_pc=80001234 and redirect_valid stable for 4 cycles; eret_count=1.
- Simultaneous requests:
  - Stimulus: exc_req=1 and eret_req=1 with exc_slot=1, epc=0x400.
  - Response: redirect_pc=BFC00380; exc_count=1, eret_count=0, last_slot=1.
- Busy drop:
  - Stimulus: second exc_req during FLUSH, and eret_req during REDIRECT.
  - Response: ignored; counters unchanged; only one redirect issued.
- Reset mid-REDIRECT:
  - Stimulus: rst pulse while redirect_valid=1.
  - Response: all outputs 0 asynchronously; no redirect after release; next exc_req behaves as the first test.
- Counter wrap:
  - Stimulus: CNT_W=4, 16 exceptions.
  - Response: exc_count returns to 0.
